// File: rtl/bomber_pkg.sv
// -----------------------------------------------------------------------------
// bomber_pkg
// Shared types and constants for the bomber game logic.
//   rng_arb_state_t : state of the RNG arbiter (IDLE, HI, ACK)
//   RNG_REQ_DEFAULT : default number of RNG requesters
// -----------------------------------------------------------------------------
package bomber_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a request; arbitration happens here
    HI   = 2'd1,  // collecting the high nibble of an 8-bit draw
    ACK  = 2'd2   // rdata valid, ack pulses for the owner
  } rng_arb_state_t;

  localparam int RNG_REQ_DEFAULT = 4;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: finds the first set request bit at or
// above ptr, wrapping modulo NREQ. Shared with other arbiters in the design.
// Ports:
//   req [NREQ-1:0] : request vector
//   ptr [PW-1:0]   : highest-priority index (must be < NREQ)
//   any            : at least one request is set
//   win [PW-1:0]   : index of the winning requester (0 when any = 0)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   win
);

  int idx;

  // NOTE: every output of a combinational block gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      // Explicit wrap so a non-power-of-2 NREQ never indexes past the top.
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// -----------------------------------------------------------------------------
// rng_arbiter
// Shares one free-running RNG nibble stream among NREQ game-logic requesters.
// Each grant takes the current nibble as the low half; a wide draw also takes
// the next cycle's nibble as the high half, so no nibble is ever handed out
// twice. Grants rotate round-robin.
// Ports:
//   Clk            : system clock
//   Reset          : synchronous active-high reset
//   randhex [3:0]  : RNG nibble, fresh every cycle
//   req  [NREQ-1:0]: level draw requests, held until ack
//   wide [NREQ-1:0]: 1 = 8-bit draw, 0 = 4-bit draw (sampled at grant)
//   ack  [NREQ-1:0]: one-hot single-cycle pulse, rdata valid for that owner
//   rdata [7:0]    : drawn value, 4-bit draws zero-extended; held between draws
//   busy           : a draw is in progress (HI or ACK)
// -----------------------------------------------------------------------------
module rng_arbiter
  import bomber_pkg::*;
#(
  parameter int NREQ = RNG_REQ_DEFAULT
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [3:0]      randhex,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] wide,
  output logic [NREQ-1:0] ack,
  output logic [7:0]      rdata,
  output logic            busy
);

  localparam int PW = $clog2(NREQ);

  rng_arb_state_t state_q;
  logic [PW-1:0]  ptr_q;
  logic [PW-1:0]  ptr_d;
  logic [PW-1:0]  owner_q;
  logic [7:0]     rdata_q;

  logic           pick_any;
  logic [PW-1:0]  pick_win;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .win (pick_win)
  );

  // Pointer moves just past the winner, wrapping explicitly so it never
  // holds a value >= NREQ.
  assign ptr_d = (pick_win == PW'(NREQ - 1)) ? '0 : pick_win + PW'(1);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      rdata_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            owner_q <= pick_win;
            rdata_q <= {4'h0, randhex};
            ptr_q   <= ptr_d;
            state_q <= wide[pick_win] ? HI : ACK;
          end
        end
        HI: begin
          rdata_q[7:4] <= randhex;
          state_q      <= ACK;
        end
        ACK: begin
          // No arbitration here: the owner's req may still be high for this
          // cycle and must not be mistaken for a new draw.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs depend on registered state/owner only; no path from req.
  assign ack   = (state_q == ACK) ? (NREQ'(1) << owner_q) : '0;
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;

endmodule

// File: doc/rng_arbiter.md
# rng_arbiter

- Shares the single free-running RNG nibble stream (`randhex[3:0]`, a new value every clock) among up to `NREQ` game-logic requesters: enemy AI direction picks, power-up drop rolls, map fill.
- Each draw is granted round-robin and delivered as a 4-bit or 8-bit value.
- No RNG nibble is ever delivered to more than one requester, and no nibble is used twice.
- Sits between the RNG instance and the game-logic clients.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8).

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high reset. One clock; all state updates on posedge `Clk`.
- `randhex` in 4: current RNG output nibble; fresh every cycle.
- `req` in NREQ: per-requester draw request, level.
- `wide` in NREQ: per-requester size select; 1 = 8-bit draw, 0 = 4-bit draw. Sampled with `req`.
- `ack` out NREQ: one-hot, single-cycle; marks `rdata` valid for that requester.
- `rdata` out 8: drawn value. 4-bit draws are zero-extended.
- `busy` out 1: high in HI and ACK states.

## Operation
- States: IDLE, HI, ACK. Encoding lives in the shared package.
- IDLE, `req` == 0: remain in IDLE; no register changes.
- IDLE, `req` != 0:
  - Winner `w` = first set bit at or above `ptr`, wrapping modulo NREQ.
  - `owner` <= w; `rdata` <= {4'h0, randhex}.
  - `ptr` <= (w+1) mod NREQ.
  - Next state: HI if `wide[w]`, else ACK.
- HI: `rdata[7:4]` <= randhex (the nibble one cycle after the low nibble); next state ACK.
- ACK: `ack[owner]` = 1, all other `ack` bits 0; no arbitration this cycle; next state IDLE.
- `rdata` holds its value until the next grant overwrites `rdata[3:0]`.
- Requester rules:
  - Hold `req` and `wide` stable from assertion until `ack`.
  - Deassert `req` on the clock edge that ends the `ack` cycle.
  - A `req` still high in the following IDLE cycle is a new draw.
- `req` dropped after grant: the draw completes and `ack` still pulses. The requester ignores it.
- `wide` changes after grant: ignored. Size is latched at grant.
- `req` asserted while busy: waits. No queueing beyond the level `req`.
- Starvation bound: any held `req` is granted within NREQ grants.

## Timing
- Reset values: `state`=IDLE, `ptr`=0, `owner`=0, `rdata`=8'h00, `ack`=0, `busy`=0.
- Reset mid-draw: the draw is abandoned with no `ack` pulse. The requester re-requests.
- Latency, `req` sampled in IDLE at edge E0:
  - narrow: `ack` high in the cycle after E0 (1 cycle); 2 cycles per draw.
  - wide: `ack` high 2 cycles after E0; 3 cycles per draw.
- `ack` and `busy` are decoded from registered `state`/`owner` only, with no combinational path from `req`.
- Nibble ownership: the low nibble is `randhex` at the grant edge; the high nibble is `randhex` at the HI edge.
- Widths:
  - `ptr` and `owner` are $clog2(NREQ) bits.
  - Wrap is explicit modulo NREQ. For non-power-of-2 NREQ, `ptr` never holds a value ≥ NREQ.

## Structure
- Shared package `bomber_pkg` gains:
  - `rng_arb_state_t` enum (IDLE, HI, ACK).
  - `RNG_REQ_DEFAULT` = 4.
- Sub-module `rr_pick`, combinational round-robin picker:
  - inputs `req`, `ptr`; outputs `any`, `win`.
  - Parameterised by NREQ; reusable by the map-write arbiter.
- The top level holds the FSM, `ptr`, `owner`, `rdata` and the output decode.
- The RNG is not instantiated here. The top-level design connects it.

## Test plan
In all scenarios the bench drives `randhex` as a counter 0,1,2,…,F,0… starting at 0 on the first cycle after `Reset` deasserts.

- Reset 2 cycles, then idle 5 cycles -> `ack`=0, `rdata`=00, `busy`=0 throughout.
- `req`=0001, `wide`=0 at cycle 0 -> cycle 1 `ack`=0001, `rdata`=00. Hold `req` -> cycle 2 regrant, cycle 3 `ack`=0001, `rdata`=02.
- `req`=0010, `wide`=0010 at cycle 0 -> cycle 1 `busy`=1, cycle 2 `ack`=0010, `rdata`=8'h10.
- `req`=1111 held, `wide`=0 -> acks in order 0001, 0010, 0100, 1000, 0001, on cycles 1, 3, 5, 7, 9; `rdata` 00, 02, 04, 06, 08.
- Wide grant to requester 2, `Reset` pulsed during HI -> no `ack`, `rdata`=00, next grant goes to requester 0 (`ptr`=0).
- NREQ=3, `req`=100 then `req`=011 -> grants to 2, then 0, then 1; `ptr` wraps 2→0 and never reaches 3.
